btb_update_queue: RTL

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

---
 rtl/btb_update_queue_pkg.sv | 15 +
 rtl/btb_update_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/btb_update_queue_pkg.sv
// Shared BTB header: geometry of the branch target buffer and the default depth
// of the update queue that feeds its single write port.
package btb_update_queue_pkg;

    localparam int NUM_BTB_ENTRIES     = 64;
    localparam int BTB_IDX             = $clog2(NUM_BTB_ENTRIES);
    localparam int BTB_TAG             = 8;
    localparam int BTB_DATA            = 32;
    localparam int UPDQ_DEPTH_DEFAULT  = 4;

    typedef logic [BTB_IDX-1:0]  btb_idx_t;
    typedef logic [BTB_TAG-1:0]  btb_tag_t;
    typedef logic [BTB_DATA-1:0] btb_data_t;

endpackage

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of BTB updates between branch resolution and the BTB write
// port; a later update to an already-queued set index replaces it in place.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int UPDQ_DEPTH = UPDQ_DEPTH_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [BTB_IDX-1:0]            in_idx,
    input  logic [BTB_TAG-1:0]            in_tag,
    input  logic [BTB_DATA-1:0]           in_data,
    output logic                          in_ready,
    input  logic                          drain_hold,
    output logic                          wr_en,
    output logic [BTB_IDX-1:0]            wr_idx,
    output logic [BTB_TAG-1:0]            wr_tag,
    output logic [BTB_DATA-1:0]           wr_data,
    output logic [$clog2(UPDQ_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(UPDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(UPDQ_DEPTH);

    logic                valid_reg [UPDQ_DEPTH];
    logic [BTB_IDX-1:0]  idx_reg   [UPDQ_DEPTH];
    logic [BTB_TAG-1:0]  tag_reg   [UPDQ_DEPTH];
    logic [BTB_DATA-1:0] data_reg  [UPDQ_DEPTH];

    logic [PTR_W-1:0]    head_reg;
    logic [PTR_W-1:0]    tail_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    count_next;

    logic                not_empty;
    logic                pop;
    logic                accept;
    logic                coalesce;
    logic                push_new;
    logic [UPDQ_DEPTH-1:0] match_vec;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg != FULL_COUNT);
    assign pop       = not_empty && !drain_hold && !reset;
    assign accept    = in_valid && in_ready;

    // The head leaving this cycle is excluded so a same-idx update is not lost
    // by merging into an entry that is already on its way out.
    generate
        for (genvar gi = 0; gi < UPDQ_DEPTH; gi++) begin : g_match
            assign match_vec[gi] = valid_reg[gi] && (idx_reg[gi] == in_idx)
                                   && !(pop && (head_reg == PTR_W'(gi)));
        end
    endgenerate

    assign coalesce   = accept && (|match_vec);
    assign push_new   = accept && !coalesce;
    assign count_next = count_reg + CNT_W'(push_new) - CNT_W'(pop);

    assign wr_en   = pop;
    assign wr_idx  = (not_empty && !reset) ? idx_reg[head_reg]  : '0;
    assign wr_tag  = (not_empty && !reset) ? tag_reg[head_reg]  : '0;
    assign wr_data = (not_empty && !reset) ? data_reg[head_reg] : '0;
    assign count   = count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            if (push_new)
                tail_reg <= tail_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Payload fields carry no reset; valid bits and count gate every use of them.
    always_ff @(posedge clock) begin
        for (int i = 0; i < UPDQ_DEPTH; i++) begin
            if (reset) begin
                valid_reg[i] <= 1'b0;
            end else if (push_new && (tail_reg == PTR_W'(i))) begin
                valid_reg[i] <= 1'b1;
                idx_reg[i]   <= in_idx;
                tag_reg[i]   <= in_tag;
                data_reg[i]  <= in_data;
            end else begin
                if (pop && (head_reg == PTR_W'(i)))
                    valid_reg[i] <= 1'b0;
                if (coalesce && match_vec[i]) begin
                    tag_reg[i]  <= in_tag;
                    data_reg[i] <= in_data;
                end
            end
        end
    end

endmodule
